// File: rtl/fifo_uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings and default framing parameters,
// common to the transmit path and the future receiver.
package fifo_uart_tx_pkg;

  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned DEF_DATA_W       = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    POP    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_e;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and wraps; tick is high in the last cycle
// of each bit period, tick_next_c flags that the following cycle will carry tick.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic tick_next_c
);

  localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  // Next count; clear holds the divider at zero so a bit period starts cleanly
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
    tick_next_c = (cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_next_c;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-draining UART 8N1 transmitter, LSB first, with registered outputs.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int unsigned DATA_W       = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int unsigned      BIT_W    = $clog2(DATA_W + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic                tx_q, tx_d;
  logic                rd_en_q, rd_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  logic baud_clear_c;
  logic tick;
  logic tick_next_c;

  // Divider is held in reset until the start bit is launched from LOAD
  assign baud_clear_c = (state_q == IDLE) || (state_q == POP) || (state_q == LOAD);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .rst         (rst),
    .clear       (baud_clear_c),
    .tick        (tick),
    .tick_next_c (tick_next_c)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    rd_en_d   = 1'b0;
    busy_d    = busy_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          state_d = POP;
          rd_en_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      POP: begin
        state_d = LOAD;
      end
      // FIFO data_out is valid now, one cycle after the pop
      LOAD: begin
        shreg_d = fifo_data;
        tx_d    = 1'b0;
        state_d = START;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
      end
      START: begin
        if (tick) begin
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = BIT_W'(1);
          state_d   = DATA;
        end
      end
      // bit_cnt_q counts bits already placed on the line
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end
    endcase

    // Registered pulse lands in the cycle that carries the stop-bit tick
    done_d = (state_d == STOP) && tick_next_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      rd_en_q   <= rd_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign fifo_rd_en = rd_en_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;

endmodule
